stage_wb: RTL
=============

Name: stage_wb

Overview:
- Write-back stage directly downstream of the memory stage.
- Holds the MEM/WB pipeline register.
- Extracts and sign/zero-extends load data from the synchronous data-memory read word, which becomes valid in the WB cycle.
- Drives the register-file write port, and drives the store-data forwarding select consumed by the memory stage.
- Keeps load data stable across WB stalls, because the RAM output is not guaranteed to hold once the memory stage issues a new access.

Parameters:
- DATA_W, 32, datapath width.
- RADDR_W, 5, register-file address width.

Ports:
- clk  input  1  core clock.
- rst  input  1  synchronous reset, active-high.
- wb_stall  input  1  hold MEM/WB register contents.
- me_valid  input  1  instruction in MEM is valid; 0 = bubble.
- me_reg_write  input  1  instruction writes rd.
- me_mem_read  input  1  instruction is a load.
- me_mem_write  input  1  instruction in MEM is a store (forwarding check).
- me_func3_code  input  3  funct3 of the MEM instruction.
- me_alu_o  input  DATA_W  ALU result / memory byte address.
- me_rd  input  RADDR_W  destination register.
- me_rs2  input  RADDR_W  store source register (forwarding check).
- wb_mem_rdata  input  DATA_W  data-memory read word, valid in the cycle after the access.
- w_regs_en  output  1  register-file write enable.
- w_regs_addr  output  RADDR_W  register-file write address.
- w_regs_data  output  DATA_W  register-file write data; also the forwarding value.
- forward_data  output  1  memory stage selects w_regs_data as store data.

Behaviour:
- MEM/WB register fields: wb_valid, wb_reg_write, wb_mem_read, wb_func3, wb_alu_o, wb_rd.
- Register update priority at posedge clk: rst first, then wb_stall (hold all fields), otherwise load from me_* inputs.
- On rst, every field clears to 0, hold_vld clears to 0 and hold_data clears to 0. All outputs are therefore 0 in the cycle after rst: w_regs_en=0, w_regs_addr=0, w_regs_data=0, forward_data=0.
- Latency: an instruction leaving MEM at edge N drives w_regs_* combinationally during cycle N, i.e. before edge N+1.
- Load-data hold buffer:
  - Capture: at an edge with wb_stall=1 and hold_vld=0, set hold_data to wb_mem_rdata and set hold_vld to 1.
  - Clear: at an edge with wb_stall=0, clear hold_vld.
  - Source selection: ld_word = hold_vld ? hold_data : wb_mem_rdata.
  - Consecutive stall cycles do not recapture.
- Load extraction uses off = wb_alu_o[1:0]:
  - LB: byte ld_word[8*off+7 : 8*off], sign-extended.
  - LBU: same byte, zero-extended.
  - LH: halfword selected by off[1], sign-extended.
  - LHU: halfword selected by off[1], zero-extended. For LH/LHU, off[0] is ignored (halfword alignment matches the store path).
  - LW: full word; off is ignored.
  - funct3 011/110/111: result 0.
- w_regs_data = wb_mem_read ? extracted load value : wb_alu_o.
- w_regs_addr = wb_rd.
- w_regs_en = wb_valid & wb_reg_write & (wb_rd != 0) & ~wb_stall. This gives exactly one write per instruction, and x0 is never written.
- forward_data = me_valid & me_mem_write & w_regs_en & (wb_rd == me_rs2). It is 0 when rs2 = x0.
- Simultaneous stall and rst: rst wins; all state clears.
- Reset asserted mid-stall: the hold buffer is discarded and the instruction in WB is dropped (no write).

Optional Feature:
- Macro: WB_RETIRE_CNT_EN.
- Defined:
  - Adds output wb_instret, 64 bits.
  - Reset to 0.
  - Increments by 1 at each edge where wb_valid=1 and wb_stall=0 (instruction retires).
  - Wraps from all-ones to 0.
- Undefined: the port and the counter are absent; all other behaviour is identical.

Test Plan:
- ALU writeback: me_valid=1, me_reg_write=1, me_rd=5, me_alu_o=32'h1234_5678, one edge -> w_regs_en=1, w_regs_addr=5, w_regs_data=32'h1234_5678.
- LB sign extension: me_mem_read=1, func3=000, alu_o low bits=2'b11, wb_mem_rdata=32'h80AB_CDEF -> w_regs_data=32'hFFFF_FF80. Same with LBU (func3=100) -> 32'h0000_0080.
- LH/LHU: alu_o low bits=2'b11, rdata=32'h8001_7FFF -> LH 32'hFFFF_8001, LHU 32'h0000_8001. Low bits=2'b00 -> LH 32'h0000_7FFF.
- Stall hold: LW in WB with rdata=32'hDEAD_BEEF, assert wb_stall for 3 cycles while rdata changes to 32'h0 -> w_regs_en=0 during the stall. After release, exactly one write of 32'hDEAD_BEEF.
- Forwarding: LW to rd=7 in WB with store rs2=7 in MEM -> forward_data=1. With rs2=7 and rd=0 -> forward_data=0 and w_regs_en=0.
- Reset mid-stall: rst during a stalled LW -> all outputs 0 next cycle, no write occurs, and wb_instret=0 when WB_RETIRE_CNT_EN is defined.

Source files
------------

// File: rtl/stage_wb.sv
// stage_wb: write-back stage that holds the MEM/WB pipeline register.
// It extracts and extends load data, drives the register-file write port,
// and drives the store-data forwarding select that the memory stage uses.
// Optional macro WB_RETIRE_CNT_EN adds a 64-bit retired-instruction counter
// (wb_instret).
module stage_wb #(
  parameter int DATA_W  = 32,
  parameter int RADDR_W = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               wb_stall,
  input  logic               me_valid,
  input  logic               me_reg_write,
  input  logic               me_mem_read,
  input  logic               me_mem_write,
  input  logic [2:0]         me_func3_code,
  input  logic [DATA_W-1:0]  me_alu_o,
  input  logic [RADDR_W-1:0] me_rd,
  input  logic [RADDR_W-1:0] me_rs2,
  input  logic [DATA_W-1:0]  wb_mem_rdata,
  output logic               w_regs_en,
  output logic [RADDR_W-1:0] w_regs_addr,
  output logic [DATA_W-1:0]  w_regs_data,
  output logic               forward_data
`ifdef WB_RETIRE_CNT_EN
  ,
  output logic [63:0]        wb_instret
`endif
);

  typedef enum logic [2:0] {
    F3_LB  = 3'b000,
    F3_LH  = 3'b001,
    F3_LW  = 3'b010,
    F3_LBU = 3'b100,
    F3_LHU = 3'b101
  } func3_e;

  logic               r_wb_valid;
  logic               r_wb_reg_write;
  logic               r_wb_mem_read;
  logic [2:0]         r_wb_func3;
  logic [DATA_W-1:0]  r_wb_alu_o;
  logic [RADDR_W-1:0] r_wb_rd;

  logic               r_hold_vld;
  logic [DATA_W-1:0]  r_hold_data;

  logic [DATA_W-1:0]  w_ld_word;
  logic [7:0]         w_byte;
  logic [15:0]        w_half;
  logic [DATA_W-1:0]  w_load_val;
  logic               w_en;

  // MEM/WB pipeline register: reset clears, stall holds, otherwise advance
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wb_valid     <= 1'b0;
      r_wb_reg_write <= 1'b0;
      r_wb_mem_read  <= 1'b0;
      r_wb_func3     <= '0;
      r_wb_alu_o     <= '0;
      r_wb_rd        <= '0;
    end else if (!wb_stall) begin
      r_wb_valid     <= me_valid;
      r_wb_reg_write <= me_reg_write;
      r_wb_mem_read  <= me_mem_read;
      r_wb_func3     <= me_func3_code;
      r_wb_alu_o     <= me_alu_o;
      r_wb_rd        <= me_rd;
    end
  end

  // Capture the RAM word once when a stall begins; the RAM may move on later
  always_ff @(posedge clk) begin
    if (rst) begin
      r_hold_vld  <= 1'b0;
      r_hold_data <= '0;
    end else if (wb_stall) begin
      if (!r_hold_vld) begin
        r_hold_vld  <= 1'b1;
        r_hold_data <= wb_mem_rdata;
      end
    end else begin
      r_hold_vld <= 1'b0;
    end
  end

  // Load extraction: select byte/halfword by address offset, then extend
  always_comb begin
    w_ld_word  = r_hold_vld ? r_hold_data : wb_mem_rdata;
    w_byte     = '0;
    w_half     = '0;
    w_load_val = '0;
    case (r_wb_alu_o[1:0])
      2'b00:   w_byte = w_ld_word[7:0];
      2'b01:   w_byte = w_ld_word[15:8];
      2'b10:   w_byte = w_ld_word[23:16];
      default: w_byte = w_ld_word[31:24];
    endcase
    w_half = r_wb_alu_o[1] ? w_ld_word[31:16] : w_ld_word[15:0];
    case (r_wb_func3)
      F3_LB:   w_load_val = {{(DATA_W-8){w_byte[7]}}, w_byte};
      F3_LBU:  w_load_val = {{(DATA_W-8){1'b0}}, w_byte};
      F3_LH:   w_load_val = {{(DATA_W-16){w_half[15]}}, w_half};
      F3_LHU:  w_load_val = {{(DATA_W-16){1'b0}}, w_half};
      F3_LW:   w_load_val = w_ld_word;
      default: w_load_val = '0;
    endcase
  end

  // Write only once per instruction (not while stalled) and never to x0
  assign w_en         = r_wb_valid & r_wb_reg_write & (r_wb_rd != '0) & ~wb_stall;
  assign w_regs_en    = w_en;
  assign w_regs_addr  = r_wb_rd;
  assign w_regs_data  = r_wb_mem_read ? w_load_val : r_wb_alu_o;
  assign forward_data = me_valid & me_mem_write & w_en & (r_wb_rd == me_rs2);

`ifdef WB_RETIRE_CNT_EN
  logic [63:0] r_instret;

  // Count each instruction that leaves WB; wraps naturally
  always_ff @(posedge clk) begin
    if (rst) begin
      r_instret <= '0;
    end else if (r_wb_valid && !wb_stall) begin
      r_instret <= r_instret + 64'd1;
    end
  end

  assign wb_instret = r_instret;
`endif

endmodule
